// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX and WB; waits for the data-SRAM response, extends load data.
// Optional MEM_FORWARD_EN drives the mem_fwd_zip bypass port (tied to zero otherwise).
module mem_stage #(
  parameter int EX_ZIP_W  = 110,
  parameter int EXC_ZIP_W = 123
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 EX_to_MEM,
  input  logic [EX_ZIP_W-1:0]  EX_to_MEM_zip,
  input  logic [EXC_ZIP_W-1:0] EX_except_zip,
  output logic                 MEM_allowin,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 WB_allowin,
  output logic                 MEM_to_WB,
  output logic [102:0]         MEM_to_WB_zip,
  output logic [EXC_ZIP_W-1:0] MEM_except_zip,
  input  logic                 wb_flush,
  output logic                 mem_ex,
  output logic [38:0]          mem_fwd_zip,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2, CANCEL = 2'd3} state_t;

  state_t               state;
  logic                 occupied;
  logic [EX_ZIP_W-1:0]  ex_zip_r;
  logic [EXC_ZIP_W-1:0] exc_zip_r;
  logic [31:0]          hold_rdata;

  logic        in_wait;
  logic        r_valid, r_gr_we, r_res_from_mem, r_mem_req, r_exc, r_ertn;
  logic [31:0] r_pc, r_ir, r_alu;
  logic [4:0]  r_waddr, r_ld_op;
  logic        valid, ready_go;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] loaded, rf_wdata;

  // A memory op waits for data_ok only when it carries no exception.
  assign in_wait = EX_to_MEM_zip[109] & EX_to_MEM_zip[5] & ~(|EX_except_zip[41:32]);

  assign r_valid        = ex_zip_r[109];
  assign r_pc           = ex_zip_r[108:77];
  assign r_ir           = ex_zip_r[76:45];
  assign r_gr_we        = ex_zip_r[44];
  assign r_waddr        = ex_zip_r[43:39];
  assign r_alu          = ex_zip_r[38:7];
  assign r_res_from_mem = ex_zip_r[6];
  assign r_mem_req      = ex_zip_r[5];
  assign r_ld_op        = ex_zip_r[4:0];
  assign r_exc          = |exc_zip_r[41:32];
  assign r_ertn         = exc_zip_r[42];

  // Handshake: a payload moves MEM->WB on a cycle where valid & ready_go & WB_allowin
  // (MEM_to_WB), and EX->MEM on a cycle where EX asserts EX_to_MEM, which EX only does
  // while MEM_allowin is high. wb_flush kills both transfers in the cycle it is seen.
  assign valid       = r_valid & occupied;
  assign ready_go    = ~valid | (state == IDLE & ~(r_mem_req & ~r_exc)) | (state == DONE);
  assign MEM_allowin = (~occupied | (ready_go & WB_allowin)) & (state != CANCEL);
  assign MEM_to_WB   = valid & ready_go & WB_allowin & ~wb_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      occupied  <= 1'b0;
      ex_zip_r  <= '0;
      exc_zip_r <= '0;
    end else if (wb_flush) begin
      occupied <= 1'b0;
    end else if (EX_to_MEM) begin
      occupied  <= 1'b1;
      ex_zip_r  <= EX_to_MEM_zip;
      exc_zip_r <= EX_except_zip;
    end else if (MEM_to_WB) begin
      occupied <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_rdata <= '0;
    end else begin
      case (state)
        IDLE:
          if (EX_to_MEM & ~wb_flush & in_wait) state <= WAIT;
        WAIT:
          if (data_sram_data_ok) begin
            if (wb_flush) begin
              state <= IDLE;
            end else begin
              hold_rdata <= data_sram_rdata;
              state      <= DONE;
            end
          end else if (wb_flush) begin
            state <= CANCEL;
          end
        DONE:
          if (wb_flush)       state <= IDLE;
          else if (EX_to_MEM) state <= in_wait ? WAIT : IDLE;
          else if (MEM_to_WB) state <= IDLE;
        CANCEL:
          if (data_sram_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

  always_comb begin
    ld_byte = hold_rdata[7:0];
    case (r_alu[1:0])
      2'd1:    ld_byte = hold_rdata[15:8];
      2'd2:    ld_byte = hold_rdata[23:16];
      2'd3:    ld_byte = hold_rdata[31:24];
      default: ld_byte = hold_rdata[7:0];
    endcase
    ld_half = r_alu[1] ? hold_rdata[31:16] : hold_rdata[15:0];
    loaded  = '0;
    if (r_ld_op[4])      loaded = {{24{ld_byte[7]}}, ld_byte};
    else if (r_ld_op[3]) loaded = {{16{ld_half[15]}}, ld_half};
    else if (r_ld_op[2]) loaded = hold_rdata;
    else if (r_ld_op[1]) loaded = {24'd0, ld_byte};
    else if (r_ld_op[0]) loaded = {16'd0, ld_half};
  end

  assign rf_wdata       = r_res_from_mem ? loaded : r_alu;
  assign MEM_to_WB_zip  = {valid, r_pc, r_ir, r_gr_we, r_waddr, rf_wdata};
  assign MEM_except_zip = exc_zip_r;
  assign mem_ex         = valid & (r_exc | r_ertn);

`ifdef MEM_FORWARD_EN
  // Bit 38 flags a load whose data is not back yet; the write-enable carries validity.
  assign mem_fwd_zip = {valid & r_res_from_mem & (state != DONE),
                        valid & r_gr_we & ~mem_ex, r_waddr, rf_wdata};
`else
  assign mem_fwd_zip = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a queue-based scoreboard.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_valid;
  logic         EX_to_MEM;
  logic [109:0] ex_zip;
  logic [122:0] ex_exc;
  logic         MEM_allowin;
  logic         data_ok;
  logic [31:0]  rdata;
  logic         WB_allowin;
  logic         MEM_to_WB;
  logic [102:0] MEM_to_WB_zip;
  logic [122:0] MEM_except_zip;
  logic         wb_flush;
  logic         mem_ex;
  logic [38:0]  mem_fwd_zip;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [102:0] exp_q[$];
  bit wb_rand = 1'b0;

  localparam logic [4:0] OP_B = 5'b10000, OP_H = 5'b01000, OP_W = 5'b00100,
                         OP_BU = 5'b00010, OP_HU = 5'b00001;
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2, S_CANCEL = 2'd3;

  always #5 clk = ~clk;

  // EX only raises its hand-off while MEM can accept.
  assign EX_to_MEM = ex_valid & MEM_allowin;

  mem_stage dut (
    .clk(clk), .rst(rst), .EX_to_MEM(EX_to_MEM), .EX_to_MEM_zip(ex_zip),
    .EX_except_zip(ex_exc), .MEM_allowin(MEM_allowin), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata), .WB_allowin(WB_allowin), .MEM_to_WB(MEM_to_WB),
    .MEM_to_WB_zip(MEM_to_WB_zip), .MEM_except_zip(MEM_except_zip), .wb_flush(wb_flush),
    .mem_ex(mem_ex), .mem_fwd_zip(mem_fwd_zip), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [109:0] mk_zip(logic [31:0] pc, logic [31:0] ir, logic we,
      logic [4:0] wa, logic [31:0] alu, logic rfm, logic mreq, logic [4:0] op);
    return {1'b1, pc, ir, we, wa, alu, rfm, mreq, op};
  endfunction

  function automatic logic [102:0] mk_exp(logic [31:0] pc, logic [31:0] ir, logic we,
      logic [4:0] wa, logic [31:0] wd);
    return {1'b1, pc, ir, we, wa, wd};
  endfunction

  // Reference load model: shift the word down by the byte offset, then extend arithmetically.
  function automatic logic [31:0] ref_load(logic [4:0] op, int off, logic [31:0] rd);
    int unsigned sh = rd >> (8 * off);
    int unsigned b  = sh % 256;
    int unsigned h  = sh % 65536;
    case (op)
      OP_B:    return (b >= 128) ? b - 256 : b;
      OP_H:    return (h >= 32768) ? h - 65536 : h;
      OP_W:    return rd;
      OP_BU:   return b;
      default: return h;
    endcase
  endfunction

  // Monitor: every transfer to WB pops one expected payload.
  initial begin
    logic [102:0] e;
    forever begin
      @(negedge clk);
      if (!rst && MEM_to_WB === 1'b1) begin
        check("queue_nonempty_at_xfer", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wb_zip", MEM_to_WB_zip, e);
        end
      end
    end
  end

  initial begin
    WB_allowin = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      WB_allowin = wb_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // Present one instruction (called at posedge+1); returns at posedge+1 after the latch edge.
  task automatic latch(input logic [109:0] z, input logic [122:0] x);
    ex_zip = z; ex_exc = x; ex_valid = 1'b1;
    @(negedge clk);
    check("allowin_before_issue", MEM_allowin, 1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic send(input logic [109:0] z, input logic [122:0] x, input logic [31:0] rd,
                      input int dly, input logic [102:0] e);
    bit acc = 1'b0;
    int n = 0;
    ex_zip = z; ex_exc = x; ex_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = EX_to_MEM;
      @(posedge clk); #1;
      n++;
    end
    ex_valid = 1'b0;
    check("accept_timeout", acc, 1);
    if (acc) begin
      exp_q.push_back(e);
      if (z[5] && !(|x[41:32])) begin
        repeat (dly) begin @(posedge clk); #1; end
        data_ok = 1'b1; rdata = rd;
        @(posedge clk); #1;
        data_ok = 1'b0;
      end
    end
  endtask

  initial begin
    logic [109:0] z;
    logic [122:0] x;
    logic [127:0] t;
    logic [31:0]  pc, ir, alu, rd, wd;
    logic [4:0]   op, wa;
    logic         we, mreq;
    int           kind, off, dly, waited;

    rst = 1'b1; ex_valid = 1'b0; ex_zip = '0; ex_exc = '0;
    data_ok = 1'b0; rdata = '0; wb_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_allowin", MEM_allowin, 1);
    check("rst_to_wb", MEM_to_WB, 0);
    check("rst_wb_zip", MEM_to_WB_zip, 0);
    check("rst_exc_zip", MEM_except_zip, 0);
    check("rst_mem_ex", mem_ex, 0);
    check("rst_fwd_zip", mem_fwd_zip, 0);
    check("rst_state", state_dbg, S_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU op: one-cycle latency.
    latch(mk_zip(32'h1c00_0000, 32'h0281_5000, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0, 5'd0), '0);
    exp_q.push_back(mk_exp(32'h1c00_0000, 32'h0281_5000, 1'b1, 5'd5, 32'h1234_5678));
    @(negedge clk);
    check("alu_xfer_next_cycle", MEM_to_WB, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("alu_single_pulse", MEM_to_WB, 0);
    @(posedge clk); #1;

    // ld_b at offset 2, data_ok three cycles after the hand-off.
    latch(mk_zip(32'h1c00_0004, 32'h2800_0000, 1'b1, 5'd7, 32'h1000_0002, 1'b1, 1'b1, OP_B), '0);
    exp_q.push_back(mk_exp(32'h1c00_0004, 32'h2800_0000, 1'b1, 5'd7, 32'hFFFF_FF80));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ldb_wait_allowin", MEM_allowin, 0);
      check("ldb_wait_no_xfer", MEM_to_WB, 0);
      @(posedge clk); #1;
    end
    data_ok = 1'b1; rdata = 32'h0080_FF00;
    @(negedge clk);
    check("ldb_no_xfer_on_data_ok", MEM_to_WB, 0);
    @(posedge clk); #1;
    data_ok = 1'b0;
    @(negedge clk);
    check("ldb_xfer_after_data_ok", MEM_to_WB, 1);
    check("ldb_state_done", state_dbg, S_DONE);
    @(posedge clk); #1;

    send(mk_zip(32'h1c00_0008, 32'h2a40_0000, 1'b1, 5'd8, 32'h2000_0002, 1'b1, 1'b1, OP_HU), '0,
         32'h8001_0000, 1, mk_exp(32'h1c00_0008, 32'h2a40_0000, 1'b1, 5'd8, 32'h0000_8001));
    send(mk_zip(32'h1c00_000c, 32'h2840_0000, 1'b1, 5'd9, 32'h2000_0002, 1'b1, 1'b1, OP_H), '0,
         32'h8001_0000, 1, mk_exp(32'h1c00_000c, 32'h2840_0000, 1'b1, 5'd9, 32'hFFFF_8001));
    repeat (2) begin @(posedge clk); #1; end

    // Flush while waiting: response must be swallowed.
    latch(mk_zip(32'h1c00_0010, 32'h2880_0000, 1'b1, 5'd10, 32'h3000_0000, 1'b1, 1'b1, OP_W), '0);
    @(negedge clk);
    check("flush_pre_state_wait", state_dbg, S_WAIT);
    @(posedge clk); #1;
    wb_flush = 1'b1;
    @(negedge clk);
    check("flush_no_xfer", MEM_to_WB, 0);
    @(posedge clk); #1;
    wb_flush = 1'b0;
    @(negedge clk);
    check("cancel_state", state_dbg, S_CANCEL);
    check("cancel_allowin_0", MEM_allowin, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("cancel_allowin_still_0", MEM_allowin, 0);
    @(posedge clk); #1;
    data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("cancel_allowin_on_data_ok", MEM_allowin, 0);
    @(posedge clk); #1;
    data_ok = 1'b0;
    @(negedge clk);
    check("cancel_back_idle", state_dbg, S_IDLE);
    check("cancel_allowin_1", MEM_allowin, 1);
    check("cancel_no_xfer", MEM_to_WB, 0);
    check("cancel_zip_invalid", MEM_to_WB_zip[102], 0);
    @(posedge clk); #1;

    // Flush beats a simultaneous hand-off.
    ex_zip = mk_zip(32'h1c00_0014, 32'h0, 1'b1, 5'd11, 32'h55, 1'b0, 1'b0, 5'd0);
    ex_exc = '0; ex_valid = 1'b1; wb_flush = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0; wb_flush = 1'b0;
    @(negedge clk);
    check("flush_blocks_latch", MEM_to_WB, 0);
    @(posedge clk); #1;

    // Misaligned-address exception with mem_req: no wait.
    x = '0;
    x[122:89] = {2'b01, 32'h0000_00ff};
    x[31:0]   = 32'h0000_2003;
    x[32]     = 1'b1;
    latch(mk_zip(32'h1c00_0018, 32'h2980_0000, 1'b0, 5'd12, 32'h0000_2003, 1'b0, 1'b1, 5'd0), x);
    exp_q.push_back(mk_exp(32'h1c00_0018, 32'h2980_0000, 1'b0, 5'd12, 32'h0000_2003));
    @(negedge clk);
    check("ale_mem_ex", mem_ex, 1);
    check("ale_exc_bit", MEM_except_zip[32], 1);
    check("ale_exc_zip", MEM_except_zip, x);
    check("ale_xfer", MEM_to_WB, 1);
    check("ale_state_idle", state_dbg, S_IDLE);
    @(posedge clk); #1;

    // Reset during a wait; a stale response afterwards is ignored.
    latch(mk_zip(32'h1c00_001c, 32'h2880_0000, 1'b1, 5'd13, 32'h4000_0000, 1'b1, 1'b1, OP_W), '0);
    @(negedge clk);
    check("rst_mid_pre_wait", state_dbg, S_WAIT);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_state", state_dbg, S_IDLE);
    check("rst_mid_wb_zip", MEM_to_WB_zip, 0);
    check("rst_mid_exc_zip", MEM_except_zip, 0);
    check("rst_mid_allowin", MEM_allowin, 1);
    check("rst_mid_mem_ex", mem_ex, 0);
    @(posedge clk); #1;
    data_ok = 1'b1; rdata = 32'h1111_2222;
    @(posedge clk); #1;
    data_ok = 1'b0;
    @(negedge clk);
    check("stale_data_ok_state", state_dbg, S_IDLE);
    check("stale_data_ok_no_xfer", MEM_to_WB, 0);
    check("stale_data_ok_allowin", MEM_allowin, 1);
    @(posedge clk); #1;

    // Randomized mix with WB back-pressure.
    wb_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      pc = $urandom; ir = $urandom; alu = $urandom; rd = $urandom;
      wa = 5'($urandom_range(0, 31));
      we = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 4);
      t = {$urandom, $urandom, $urandom, $urandom};
      x = t[122:0];
      x[42:32] = '0;
      if (kind >= 4 && kind <= 6) begin
        case ($urandom_range(0, 4))
          0: op = OP_B;
          1: op = OP_H;
          2: op = OP_W;
          3: op = OP_BU;
          default: op = OP_HU;
        endcase
        if (op == OP_W)                    off = 0;
        else if (op == OP_H || op == OP_HU) off = 2 * $urandom_range(0, 1);
        else                               off = $urandom_range(0, 3);
        alu = (alu & 32'hFFFF_FFFC) | 32'(off);
        wd = ref_load(op, off, rd);
        z = mk_zip(pc, ir, we, wa, alu, 1'b1, 1'b1, op);
        send(z, x, rd, dly, mk_exp(pc, ir, we, wa, wd));
      end else if (kind == 7) begin
        z = mk_zip(pc, ir, 1'b0, wa, alu, 1'b0, 1'b1, OP_W);
        send(z, x, rd, dly, mk_exp(pc, ir, 1'b0, wa, alu));
      end else if (kind == 8) begin
        x[32 + $urandom_range(0, 9)] = 1'b1;
        mreq = 1'($urandom_range(0, 1));
        z = mk_zip(pc, ir, we, wa, alu, 1'b0, mreq, 5'd0);
        send(z, x, rd, dly, mk_exp(pc, ir, we, wa, alu));
      end else begin
        z = mk_zip(pc, ir, we, wa, alu, 1'b0, 1'b0, 5'd0);
        send(z, x, rd, dly, mk_exp(pc, ir, we, wa, alu));
      end
    end
    wb_rand = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly upstream of the writeback stage.
- Latches the EX payload and waits for the data-SRAM response of a load or store issued by EX.
- Extracts and extends load data, then hands the writeback payload and the exception/CSR payload to WB through a valid/allowin handshake.
- Handles flush from WB, including cancelling an in-flight data response.

Parameters:
- EX_ZIP_W, 110, width of EX_to_MEM_zip.
- EXC_ZIP_W, 123, width of the exception/CSR zip (same layout in and out).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- EX_to_MEM  input  1  EX hands an instruction this cycle
- EX_to_MEM_zip  input  110  {valid, pc[32], IR[32], gr_we, rf_waddr[5], alu_result[32], res_from_mem, mem_req, ld_op[5]={b,h,w,bu,hu}}
- EX_except_zip  input  123  {csr_re, csr_we, csr_wmask[32], csr_wvalue[32], csr_num[14], inst_ertn, adef, tlbr, pif, pme, ppi, sys, brk, ine, int, ale, vaddr[32]}
- MEM_allowin  output  1  MEM can accept from EX
- data_sram_data_ok  input  1  response pulse for the outstanding request
- data_sram_rdata  input  32  response data
- WB_allowin  input  1  WB can accept
- MEM_to_WB  output  1  transfer pulse to WB
- MEM_to_WB_zip  output  103  {valid, pc, IR, gr_we, rf_waddr, rf_wdata}
- MEM_except_zip  output  123  EX_except_zip passed through unchanged
- wb_flush  input  1  wb_ex | ertn_flush from WB
- mem_ex  output  1  valid & (any except bit | inst_ertn); EX uses it to suppress later stores
- mem_fwd_zip  output  39  {fwd_valid, fwd_we, fwd_waddr[5], fwd_wdata[32]}

Behaviour:
- Registers:
  - Payload registers load on EX_to_MEM.
  - valid = zip valid bit & occupied.
  - occupied sets on EX_to_MEM, clears on MEM_to_WB without a new EX_to_MEM, and clears on wb_flush.
- State machine (2-bit):
  - IDLE:
    - On EX_to_MEM with mem_req=1 and no except bit set -> WAIT.
    - With mem_req=0 -> IDLE; instruction is ready immediately.
  - WAIT:
    - data_ok captures rdata into a holding register -> DONE.
    - wb_flush without data_ok -> CANCEL.
    - wb_flush together with data_ok -> IDLE; the response is dropped.
  - DONE: on MEM_to_WB -> IDLE, or -> WAIT if a new memory instruction enters the same cycle.
  - CANCEL: swallows the next data_ok -> IDLE; MEM_allowin=0 while in CANCEL.
- Handshake:
  - ready_go = ~valid | (state==IDLE & ~mem_req) | state==DONE.
  - MEM_allowin = (~occupied | (ready_go & WB_allowin)) & state!=CANCEL.
  - MEM_to_WB = valid & ready_go & WB_allowin & ~wb_flush.
  - Latency: 1 cycle for a non-memory instruction. For a load, data_ok arrives cycle N and the transfer happens at cycle N+1.
- Load extraction, by alu_result[1:0]:
  - ld_b/ld_bu select byte 0..3; ld_h/ld_hu select halfword 0 or 2; ld_w takes the full word.
  - b and h sign-extend to 32 bits; bu and hu zero-extend.
  - rf_wdata = res_from_mem ? loaded : alu_result.
  - Stores: rf_wdata = alu_result and gr_we is passed through, which is 0 for stores.
- Exceptions: if any except bit is set, mem_req is ignored (no wait) and the instruction is passed to WB as ready.
- Reset:
  - occupied=0, state=IDLE, holding register=0.
  - MEM_to_WB=0; MEM_to_WB_zip=0; MEM_except_zip=0.
  - mem_ex=0; mem_fwd_zip=0; MEM_allowin=1.
- Simultaneous events:
  - wb_flush has priority over EX_to_MEM; the new instruction is not latched.
  - data_ok in IDLE outside CANCEL is ignored.

Optional Feature:
- Macro MEM_FORWARD_EN.
- Defined:
  - fwd_valid = valid.
  - fwd_we = gr_we & ~mem_ex.
  - fwd_waddr = rf_waddr.
  - fwd_wdata = final rf_wdata.
  - While a load waits, fwd_valid=1 with fwd_wdata invalid; ID must stall on (fwd_valid & state!=DONE & res_from_mem). To expose this, mem_fwd_zip[38] is replaced by a "load-pending" flag.
- Undefined: mem_fwd_zip is tied to 0 and ID relies on stall-only hazard handling.

Test Plan:
- ALU instruction, alu_result=0x12345678, gr_we=1, waddr=5, WB_allowin=1 -> MEM_to_WB pulse one cycle after EX_to_MEM; zip wdata=0x12345678, waddr=5.
- ld_b, alu_result[1:0]=2, rdata=0x0080FF00, data_ok 3 cycles later -> wdata=0xFFFFFF80, MEM_to_WB on the cycle after data_ok, MEM_allowin=0 during the wait.
- ld_hu, offset 2, rdata=0x8001_0000 -> wdata=0x00008001; ld_h with the same inputs -> 0xFFFF8001.
- Load in WAIT, wb_flush, data_ok 2 cycles later -> state CANCEL, MEM_allowin=0 until data_ok, no MEM_to_WB, then IDLE with MEM_allowin=1.
- Instruction with ale=1 and mem_req=1 -> no wait, mem_ex=1, MEM_except_zip ale bit=1, MEM_to_WB after 1 cycle.
- rst asserted mid-WAIT -> next cycle state IDLE, all zips 0, MEM_allowin=1; a later stale data_ok is ignored.
